// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with trap on illegal op or memory time-out
module core_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        dec_illegal,
  input  logic        dec_reg_we,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_branch,
  input  logic        dec_is_jump,
  input  logic [1:0]  dec_aluop1_type,
  input  logic [1:0]  dec_aluop2_type,
  input  logic        br_taken,
  output logic [1:0]  aluop1_type,
  output logic [1:0]  aluop2_type,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halt,
  output logic [2:0]  state,
  output logic [31:0] instret
);
  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t st;
  logic [31:0] instret_q, tcnt;
  logic r_reg_we, r_load, r_store, r_branch, r_jump, r_taken;
  logic [1:0] r_op1, r_op2;
  logic tout, run, in_ex, in_mem, in_wb;
  assign tout = TIMEOUT != 0 && tcnt == TO_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= FETCH;
      instret_q <= '0;
      tcnt <= '0;
      {r_reg_we, r_load, r_store, r_branch, r_jump, r_taken} <= '0;
      r_op1 <= OP_TYPE_NONE;
      r_op2 <= OP_TYPE_NONE;
    end else begin
      tcnt <= ((st == FETCH && !imem_ack) || (st == MEM && !dmem_ack)) ? tcnt + 32'd1 : '0;
      case (st)
        FETCH: st <= imem_ack ? DECODE : tout ? TRAP : FETCH;
        DECODE: begin
          st <= dec_illegal ? TRAP : EXEC;
          if (!dec_illegal) begin
            {r_reg_we, r_load, r_store, r_branch, r_jump} <= {dec_reg_we, dec_is_load, dec_is_store, dec_is_branch, dec_is_jump};
            r_op1 <= dec_aluop1_type;
            r_op2 <= dec_aluop2_type;
          end
        end
        EXEC: begin
          r_taken <= br_taken;
          st <= (r_load || r_store) ? MEM : WB;
        end
        MEM: begin
          st <= dmem_ack ? (r_store ? FETCH : WB) : tout ? TRAP : MEM;
          if (dmem_ack && r_store) instret_q <= instret_q + 32'd1;
        end
        WB: begin
          st <= FETCH;
          instret_q <= instret_q + 32'd1;
        end
        TRAP: st <= TRAP;
        default: st <= TRAP;
      endcase
    end
  end
  assign run = !rst;
  assign in_ex = run && (st == EXEC || st == MEM);
  assign in_mem = run && st == MEM;
  assign in_wb = run && st == WB;
  assign imem_req = run && st == FETCH;
  assign ir_we = imem_req && imem_ack;
  assign dmem_req = in_mem;
  assign dmem_we = in_mem && r_store;
  assign aluop1_type = in_ex ? r_op1 : OP_TYPE_NONE;
  assign aluop2_type = in_ex ? r_op2 : OP_TYPE_NONE;
  assign reg_we = in_wb && r_reg_we;
  assign pc_we = in_wb || (in_mem && dmem_ack && r_store);
  assign pc_sel = in_wb && (r_jump || (r_branch && r_taken));
  assign halt = run && st == TRAP;
  assign state = run ? st : 3'd0;
  assign instret = run ? instret_q : '0;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven and directed checks of the core sequencer
module tb_core_sequencer;
  localparam logic [1:0] NONE = 2'd0, REG = 2'd1, IMM = 2'd2, PCT = 2'd3;
  localparam logic [8:0] IA = 9'h100, DA = 9'h080, ILL = 9'h040, RW = 9'h020, LD = 9'h010, SD = 9'h008, BR = 9'h004, JP = 9'h002, TK = 9'h001;
  localparam logic [7:0] IREQ = 8'h80, IRWE = 8'h40, DREQ = 8'h20, DWE = 8'h10, RWE = 8'h08, PCWE = 8'h04, PCSEL = 8'h02, HALT = 8'h01;
  typedef struct {
    string nm;
    logic [8:0] in;
    logic [1:0] o1, o2;
    logic [2:0] es;
    logic [7:0] eo;
    logic [1:0] e1, e2;
    logic [31:0] ei;
  } vec_t;
  logic clk = 0, rst = 1;
  logic ia, da, ill, drwe, dld, dst, dbr, djp, tk;
  logic [1:0] do1, do2, aluop1_type, aluop2_type;
  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, halt;
  logic [2:0] state;
  logic [31:0] instret;
  logic [7:0] outs;
  int checks = 0, errors = 0;
  vec_t vq[$];
  core_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(ia), .ir_we(ir_we),
    .dec_illegal(ill), .dec_reg_we(drwe), .dec_is_load(dld), .dec_is_store(dst),
    .dec_is_branch(dbr), .dec_is_jump(djp), .dec_aluop1_type(do1), .dec_aluop2_type(do2),
    .br_taken(tk), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(da), .reg_we(reg_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt), .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  assign outs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, halt};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [8:0] i, input logic [1:0] a, input logic [1:0] b);
    {ia, da, ill, drwe, dld, dst, dbr, djp, tk} = i;
    do1 = a;
    do2 = b;
  endtask
  task automatic add(input string n, input logic [8:0] i, input logic [1:0] a, input logic [1:0] b,
                     input logic [2:0] s, input logic [7:0] o, input logic [1:0] x, input logic [1:0] y, input logic [31:0] r);
    vec_t v;
    v.nm = n; v.in = i; v.o1 = a; v.o2 = b; v.es = s; v.eo = o; v.e1 = x; v.e2 = y; v.ei = r;
    vq.push_back(v);
  endtask
  task automatic cyc(input logic [8:0] i, input logic [1:0] a, input logic [1:0] b);
    drive(i, a, b);
    @(negedge clk);
  endtask
  initial begin
    add("alu_fetch", IA|RW, REG, IMM, 0, IREQ|IRWE, NONE, NONE, 0);
    add("alu_dec",   RW, REG, IMM, 1, 0, NONE, NONE, 0);
    add("alu_exec",  RW, REG, IMM, 2, 0, REG, IMM, 0);
    add("alu_wb",    RW, REG, IMM, 4, RWE|PCWE, NONE, NONE, 0);
    add("ld_fetch",  IA|RW|LD, REG, IMM, 0, IREQ|IRWE, NONE, NONE, 1);
    add("ld_dec",    RW|LD, REG, IMM, 1, 0, NONE, NONE, 1);
    add("ld_exec",   RW|LD, REG, IMM, 2, 0, REG, IMM, 1);
    add("ld_mem1",   RW|LD, REG, IMM, 3, DREQ, REG, IMM, 1);
    add("ld_mem2",   RW|LD, REG, IMM, 3, DREQ, REG, IMM, 1);
    add("ld_mem3",   RW|LD, REG, IMM, 3, DREQ, REG, IMM, 1);
    add("ld_mem4",   DA|RW|LD, REG, IMM, 3, DREQ, REG, IMM, 1);
    add("ld_wb",     RW|LD, REG, IMM, 4, RWE|PCWE, NONE, NONE, 1);
    add("st_fetch",  IA|SD, REG, IMM, 0, IREQ|IRWE, NONE, NONE, 2);
    add("st_dec",    SD, REG, IMM, 1, 0, NONE, NONE, 2);
    add("st_exec",   SD, REG, IMM, 2, 0, REG, IMM, 2);
    add("st_mem1",   SD, REG, IMM, 3, DREQ|DWE, REG, IMM, 2);
    add("st_mem2",   SD, REG, IMM, 3, DREQ|DWE, REG, IMM, 2);
    add("st_mem3",   SD, REG, IMM, 3, DREQ|DWE, REG, IMM, 2);
    add("st_mem4",   DA|SD, REG, IMM, 3, DREQ|DWE|PCWE, REG, IMM, 2);
    add("st_next",   DA, NONE, NONE, 0, IREQ, NONE, NONE, 3);
    add("bt_fetch",  IA|BR, PCT, IMM, 0, IREQ|IRWE, NONE, NONE, 3);
    add("bt_dec",    BR, PCT, IMM, 1, 0, NONE, NONE, 3);
    add("bt_exec",   BR|TK, PCT, IMM, 2, 0, PCT, IMM, 3);
    add("bt_wb",     BR, PCT, IMM, 4, PCWE|PCSEL, NONE, NONE, 3);
    add("bn_fetch",  IA|BR, PCT, IMM, 0, IREQ|IRWE, NONE, NONE, 4);
    add("bn_dec",    IA|DA|BR, PCT, IMM, 1, 0, NONE, NONE, 4);
    add("bn_exec",   BR, PCT, IMM, 2, 0, PCT, IMM, 4);
    add("bn_wb",     IA|BR|TK, PCT, IMM, 4, PCWE, NONE, NONE, 4);
    add("j_fetch",   IA|JP|RW, PCT, IMM, 0, IREQ|IRWE, NONE, NONE, 5);
    add("j_dec",     JP|RW, PCT, IMM, 1, 0, NONE, NONE, 5);
    add("j_exec",    JP|RW, PCT, IMM, 2, 0, PCT, IMM, 5);
    add("j_wb",      JP|RW, PCT, IMM, 4, RWE|PCWE|PCSEL, NONE, NONE, 5);
    add("to_f1",     0, NONE, NONE, 0, IREQ, NONE, NONE, 6);
    add("to_f2",     0, NONE, NONE, 0, IREQ, NONE, NONE, 6);
    add("to_f3",     0, NONE, NONE, 0, IREQ, NONE, NONE, 6);
    add("to_f4_ack", IA, NONE, NONE, 0, IREQ|IRWE, NONE, NONE, 6);
    add("ill_dec",   ILL|RW, REG, IMM, 1, 0, NONE, NONE, 6);
    add("trap1",     RW, REG, IMM, 5, HALT, NONE, NONE, 6);
    add("trap2",     IA|DA|RW, REG, IMM, 5, HALT, NONE, NONE, 6);
    add("trap3",     IA|DA|RW, REG, IMM, 5, HALT, NONE, NONE, 6);
    drive(IA|DA, REG, IMM);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", 32'(outs), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_op1", 32'(aluop1_type), 32'(NONE));
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst = 0;
    foreach (vq[k]) begin
      drive(vq[k].in, vq[k].o1, vq[k].o2);
      #1;
      chk({vq[k].nm, "_state"}, 32'(state), 32'(vq[k].es));
      chk({vq[k].nm, "_outs"}, 32'(outs), 32'(vq[k].eo));
      chk({vq[k].nm, "_op1"}, 32'(aluop1_type), 32'(vq[k].e1));
      chk({vq[k].nm, "_op2"}, 32'(aluop2_type), 32'(vq[k].e2));
      chk({vq[k].nm, "_instret"}, instret, vq[k].ei);
      @(negedge clk);
    end
    rst = 1;
    cyc(0, NONE, NONE);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      drive(0, NONE, NONE);
      #1;
      chk("nack_fetch_state", 32'(state), 0);
      @(negedge clk);
    end
    #1;
    chk("nack_trap_state", 32'(state), 5);
    chk("nack_trap_outs", 32'(outs), 32'(HALT));
    @(negedge clk);
    rst = 1;
    cyc(0, NONE, NONE);
    rst = 0;
    cyc(IA|RW, REG, IMM);
    cyc(RW, REG, IMM);
    cyc(RW, REG, IMM);
    cyc(RW, REG, IMM);
    #1;
    chk("pre_abort_instret", instret, 1);
    @(negedge clk);
    cyc(IA|SD, REG, IMM);
    cyc(SD, REG, IMM);
    cyc(SD, REG, IMM);
    #1;
    chk("abort_in_mem", 32'(state), 3);
    @(negedge clk);
    rst = 1;
    drive(DA|SD, REG, IMM);
    #1;
    chk("abort_rst_outs", 32'(outs), 0);
    @(negedge clk);
    rst = 0;
    drive(0, NONE, NONE);
    #1;
    chk("abort_restart_state", 32'(state), 0);
    chk("abort_restart_outs", 32'(outs), 32'(IREQ));
    chk("abort_instret", instret, 0);
    @(negedge clk);
    cyc(IA|RW, REG, IMM);
    cyc(RW, REG, IMM);
    cyc(RW, REG, IMM);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_wb_state", 32'(state), 4);
    chk("wrap_pre", instret, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    chk("wrap_post", instret, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
